// File: rtl/irrigation_valve_sequencer_if.sv
// Permit/mode/abort controls into the valve sequencer and valve/status outputs back.
interface irrigation_valve_sequencer_if;
  logic       irrigation;
  logic       use_sprinkler;
  logic       abort;
  logic       dripper;
  logic       sprinkler;
  logic       busy;
  logic       timeout;
  logic [1:0] state;

  modport master (
    output irrigation, use_sprinkler, abort,
    input  dripper, sprinkler, busy, timeout, state
  );

  modport slave (
    input  irrigation, use_sprinkler, abort,
    output dripper, sprinkler, busy, timeout, state
  );
endinterface

// File: rtl/irrigation_valve_sequencer.sv
// Debounces the irrigation permit and drives one valve with min/max on-time and cooldown.
module irrigation_valve_sequencer #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ARM_CYCLES = 4,
  parameter int unsigned MIN_ON     = 8,
  parameter int unsigned MAX_ON     = 64,
  parameter int unsigned COOLDOWN   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  irrigation_valve_sequencer_if.slave   bus
);

  localparam longint unsigned CNT_RANGE = 64'(1) << CNT_W;

  if (ARM_CYCLES < 1 || MIN_ON < 1 || MAX_ON <= MIN_ON || COOLDOWN < 1 ||
      64'(ARM_CYCLES) >= CNT_RANGE || 64'(MIN_ON) >= CNT_RANGE ||
      64'(MAX_ON) >= CNT_RANGE || 64'(COOLDOWN) >= CNT_RANGE) begin : g_param_check
    $error("irrigation_valve_sequencer: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] ARM_LIM  = CNT_W'(ARM_CYCLES);
  localparam logic [CNT_W-1:0] MIN_LIM  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] MAX_LIM  = CNT_W'(MAX_ON - 1);
  localparam logic [CNT_W-1:0] COOL_LIM = CNT_W'(COOLDOWN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    COOL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             timeout_q, timeout_d;
  logic             dripper_q, sprinkler_q, busy_q;

  // Next-state logic; one shared counter times every phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (bus.irrigation && !bus.abort) begin
          state_d = ARM;
          cnt_d   = CNT_ONE;
        end
      end
      ARM: begin
        if (bus.abort || !bus.irrigation) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == ARM_LIM) begin
          state_d   = RUN;
          cnt_d     = '0;
          mode_d    = bus.use_sprinkler;
          timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = COOL;
          cnt_d   = '0;
        end else if (cnt_q == MAX_LIM) begin
          state_d   = COOL;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else if (!bus.irrigation && cnt_q >= MIN_LIM) begin
          state_d = COOL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      COOL: begin
        if (cnt_q == COOL_LIM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Valve and busy flags are registered from the next state so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      timeout_q   <= 1'b0;
      dripper_q   <= 1'b0;
      sprinkler_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      timeout_q   <= timeout_d;
      dripper_q   <= (state_d == RUN) && !mode_d;
      sprinkler_q <= (state_d == RUN) && mode_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.dripper   = dripper_q;
  assign bus.sprinkler = sprinkler_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;
  assign bus.state     = state_q;

endmodule
